// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage MIPS pipeline.
//
// Picks operands (regfile / M-forward / W-forward), evaluates the ALU and
// owns the E/M pipeline register. With EX_MUL_EN defined, ALU op 11 (MUL)
// is an iterative multiply. It holds E for MUL_CYCLES cycles through busy_E
// and then retires the latched product into M. Without EX_MUL_EN, op 11 is a
// single-cycle op that returns 0 and busy_E is tied low.
//
// Optional feature macro: EX_MUL_EN
//
// Parameters:
//   MUL_CYCLES     cycles busy_E stays high for one multiply (>= 1)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   hazard_data[5:0]    {forwardA[1:0], forwardB[1:0], stallE, flushM}
//   valid_E             instruction present in E
//   rs_data_E/rt_data_E regfile operand values
//   imm_E               extended immediate
//   alu_src_E           1: operand B = imm_E
//   alu_op_E[3:0]       ALU operation
//   write_reg_E, reg_write_E, mem_to_reg_E, mem_write_E   E controls
//   alu_result_M_fwd    M-stage result for forwarding
//   result_W            W-stage writeback value for forwarding
//   busy_E              multiply occupying E (ORed into stalls upstream)
//   valid_M, alu_result_M, write_data_M, write_reg_M,
//   reg_write_M, mem_to_reg_M, mem_write_M   registered E/M outputs
//   mul_state_dbg[1:0]  multiply FSM state (0 IDLE, 1 BUSY, 2 DONE;
//                       always 0 without EX_MUL_EN)
//
// Forward selects: 00 regfile, 01 result_W, 10 alu_result_M_fwd,
// 11 falls back to regfile.
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hazard_data,
  input  logic        valid_E,
  input  logic [31:0] rs_data_E,
  input  logic [31:0] rt_data_E,
  input  logic [31:0] imm_E,
  input  logic        alu_src_E,
  input  logic [3:0]  alu_op_E,
  input  logic [4:0]  write_reg_E,
  input  logic        reg_write_E,
  input  logic        mem_to_reg_E,
  input  logic        mem_write_E,
  input  logic [31:0] alu_result_M_fwd,
  input  logic [31:0] result_W,
  output logic        busy_E,
  output logic        valid_M,
  output logic [31:0] alu_result_M,
  output logic [31:0] write_data_M,
  output logic [4:0]  write_reg_M,
  output logic        reg_write_M,
  output logic        mem_to_reg_M,
  output logic        mem_write_M,
  output logic [1:0]  mul_state_dbg
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall_e;
  logic       flush_m;

  assign forward_a = hazard_data[5:4];
  assign forward_b = hazard_data[3:2];
  assign stall_e   = hazard_data[1];
  assign flush_m   = hazard_data[0];

  // ---------------- operand selection ----------------
  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;

  always_comb begin
    src_a = rs_data_E;
    case (forward_a)
      2'b01:   src_a = result_W;
      2'b10:   src_a = alu_result_M_fwd;
      default: src_a = rs_data_E;
    endcase
  end

  always_comb begin
    fwd_b = rt_data_E;
    case (forward_b)
      2'b01:   fwd_b = result_W;
      2'b10:   fwd_b = alu_result_M_fwd;
      default: fwd_b = rt_data_E;
    endcase
  end

  assign src_b = alu_src_E ? imm_E : fwd_b;

  // ---------------- single-cycle ALU ----------------
  // MUL is not evaluated here: with the multiplier enabled the product comes
  // from the latched operands, otherwise op 11 is defined to return 0.
  logic [31:0] alu_y;

  always_comb begin
    alu_y = '0;
    case (alu_op_E)
      OP_ADD:  alu_y = src_a + src_b;
      OP_SUB:  alu_y = src_a - src_b;
      OP_AND:  alu_y = src_a & src_b;
      OP_OR:   alu_y = src_a | src_b;
      OP_XOR:  alu_y = src_a ^ src_b;
      OP_SLT:  alu_y = {31'd0, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_y = {31'd0, (src_a < src_b)};
      OP_SLL:  alu_y = src_a << src_b[4:0];
      OP_SRL:  alu_y = src_a >> src_b[4:0];
      OP_SRA:  alu_y = $unsigned($signed(src_a) >>> src_b[4:0]);
      OP_LUI:  alu_y = {src_b[15:0], 16'd0};
      default: alu_y = '0;
    endcase
  end

  // ---------------- multiply sequencer ----------------
  logic        mul_bubble;   // E holds a multiply that is not finished yet
  logic        mul_done;     // E holds a finished multiply; retire it
  logic [31:0] mul_product;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // BUSY runs MUL_CYCLES-1 cycles after the IDLE start cycle, so the counter
  // is loaded with MUL_CYCLES-2 and DONE is entered once it reaches zero.
  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MUL_CYCLES > 1) ? CW'(MUL_CYCLES - 2) : '0;

  mul_state_t  state_q;
  mul_state_t  state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic        mul_in_e;

  assign mul_in_e = valid_E && (alu_op_E == OP_MUL);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // counter and operand latches
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else if (state_q == MUL_IDLE && mul_in_e) begin
      cnt_q   <= CNT_LOAD;
      mul_a_q <= src_a;
      mul_b_q <= src_b;
    end else if (state_q == MUL_BUSY && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (mul_in_e) state_d = (MUL_CYCLES > 1) ? MUL_BUSY : MUL_DONE;
      MUL_BUSY: if (cnt_q == '0) state_d = MUL_DONE;
      MUL_DONE: state_d = stall_e ? MUL_DONE : MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    busy_E     = (state_q == MUL_BUSY) || (state_q == MUL_IDLE && mul_in_e);
    mul_bubble = busy_E;
    mul_done   = (state_q == MUL_DONE);
  end

  assign mul_product   = mul_a_q * mul_b_q;
  assign mul_state_dbg = state_q;
`else
  assign busy_E        = 1'b0;
  assign mul_bubble    = 1'b0;
  assign mul_done      = 1'b0;
  assign mul_product   = '0;
  assign mul_state_dbg = 2'd0;
`endif

  // ---------------- E/M pipeline register ----------------
  // Priority: reset, flushM bubble, unfinished-multiply bubble, stallE hold,
  // capture. Controls are qualified by valid_E; data fields are not.
  always_ff @(posedge clk) begin
    if (reset || flush_m || mul_bubble) begin
      valid_M      <= 1'b0;
      alu_result_M <= '0;
      write_data_M <= '0;
      write_reg_M  <= '0;
      reg_write_M  <= 1'b0;
      mem_to_reg_M <= 1'b0;
      mem_write_M  <= 1'b0;
    end else if (!stall_e) begin
      valid_M      <= valid_E;
      alu_result_M <= mul_done ? mul_product : alu_y;
      write_data_M <= fwd_b;
      write_reg_M  <= write_reg_E;
      reg_write_M  <= reg_write_E  && valid_E;
      mem_to_reg_M <= mem_to_reg_E && valid_E;
      mem_write_M  <= mem_write_E  && valid_E;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- bench for ex_stage: reset check, a table of directed
// vectors, randomized traffic against a reference model, and multiply
// sequences when EX_MUL_EN is defined.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  localparam int MC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  fa, fb;
  logic        stall_e, flush_m;
  logic [5:0]  hazard_data;
  logic        valid_E;
  logic [31:0] rs_data_E, rt_data_E, imm_E;
  logic        alu_src_E;
  logic [3:0]  alu_op_E;
  logic [4:0]  write_reg_E;
  logic        reg_write_E, mem_to_reg_E, mem_write_E;
  logic [31:0] alu_result_M_fwd, result_W;
  logic        busy_E, valid_M;
  logic [31:0] alu_result_M, write_data_M;
  logic [4:0]  write_reg_M;
  logic        reg_write_M, mem_to_reg_M, mem_write_M;
  logic [1:0]  mul_state_dbg;

  assign hazard_data = {fa, fb, stall_e, flush_m};

  ex_stage #(.MUL_CYCLES(MC)) dut (
    .clk              (clk),
    .reset            (reset),
    .hazard_data      (hazard_data),
    .valid_E          (valid_E),
    .rs_data_E        (rs_data_E),
    .rt_data_E        (rt_data_E),
    .imm_E            (imm_E),
    .alu_src_E        (alu_src_E),
    .alu_op_E         (alu_op_E),
    .write_reg_E      (write_reg_E),
    .reg_write_E      (reg_write_E),
    .mem_to_reg_E     (mem_to_reg_E),
    .mem_write_E      (mem_write_E),
    .alu_result_M_fwd (alu_result_M_fwd),
    .result_W         (result_W),
    .busy_E           (busy_E),
    .valid_M          (valid_M),
    .alu_result_M     (alu_result_M),
    .write_data_M     (write_data_M),
    .write_reg_M      (write_reg_M),
    .reg_write_M      (reg_write_M),
    .mem_to_reg_M     (mem_to_reg_M),
    .mem_write_M      (mem_write_M),
    .mul_state_dbg    (mul_state_dbg)
  );

  // ---------------- records ----------------
  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, mr, mw;
  } m_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, imm;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] mf, w;
    logic        stall, flush, valid;
    logic [4:0]  wr;
    logic        rw, mr, mw;
    m_t          exp;
  } vec_t;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_m(input string tag, input m_t e);
    check({tag, "_valid_M"},      32'(valid_M),      32'(e.valid));
    check({tag, "_alu_result_M"}, alu_result_M,      e.res);
    check({tag, "_write_data_M"}, write_data_M,      e.wd);
    check({tag, "_write_reg_M"},  32'(write_reg_M),  32'(e.wr));
    check({tag, "_reg_write_M"},  32'(reg_write_M),  32'(e.rw));
    check({tag, "_mem_to_reg_M"}, 32'(mem_to_reg_M), 32'(e.mr));
    check({tag, "_mem_write_M"},  32'(mem_write_M),  32'(e.mw));
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'b01) return w;
    if (sel == 2'b10) return m;
    return rf;
  endfunction

  // Arithmetic definitions: shifts as multiply/divide by a power of two,
  // SRA as floor division, compares on 64-bit extended values.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, p, q;
    logic [63:0] ua, ub, t;
    int sh;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    p  = 64'sd1 << sh;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd7:  begin t = ua * 64'(p); return t[31:0]; end
      4'd8:  begin t = ua / 64'(p); return t[31:0]; end
      4'd9:  begin
               if (sa >= 0) q = sa / p;
               else q = -((-sa + p - 1) / p);
               return q[31:0];
             end
      4'd10: begin t = ub * 64'd65536; return t[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    fa = 2'b00; fb = 2'b00; stall_e = 1'b0; flush_m = 1'b0;
    valid_E = 1'b0; rs_data_E = '0; rt_data_E = '0; imm_E = '0;
    alu_src_E = 1'b0; alu_op_E = 4'd0; write_reg_E = '0;
    reg_write_E = 1'b0; mem_to_reg_E = 1'b0; mem_write_E = 1'b0;
    alu_result_M_fwd = '0; result_W = '0;
  endtask

  task automatic apply(input vec_t v);
    alu_op_E = v.op; rs_data_E = v.rs; rt_data_E = v.rt; imm_E = v.imm;
    alu_src_E = v.src; fa = v.fa; fb = v.fb; alu_result_M_fwd = v.mf;
    result_W = v.w; stall_e = v.stall; flush_m = v.flush; valid_E = v.valid;
    write_reg_E = v.wr; reg_write_E = v.rw; mem_to_reg_E = v.mr; mem_write_E = v.mw;
  endtask

  // Synchronous reset; returns at posedge+#1 with reset released.
  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] imm, input logic src, input logic [1:0] a_sel,
                              input logic [1:0] b_sel, input logic [31:0] mf, input logic [31:0] w,
                              input logic st, input logic fl, input logic vl, input logic [4:0] wr,
                              input logic rw, input logic mr, input logic mw,
                              input logic ev, input logic [31:0] eres, input logic [31:0] ewd,
                              input logic [4:0] ewr, input logic erw, input logic emr, input logic emw);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.imm = imm; v.src = src; v.fa = a_sel; v.fb = b_sel;
    v.mf = mf; v.w = w; v.stall = st; v.flush = fl; v.valid = vl; v.wr = wr;
    v.rw = rw; v.mr = mr; v.mw = mw;
    v.exp.valid = ev; v.exp.res = eres; v.exp.wd = ewd; v.exp.wr = ewr;
    v.exp.rw = erw; v.exp.mr = emr; v.exp.mw = emw;
    return v;
  endfunction

`ifdef EX_MUL_EN
  // Called at posedge+#1; returns at posedge+#1 with E idle.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    drive_idle();
    alu_op_E = 4'd11; rs_data_E = a; imm_E = b; alu_src_E = 1'b1;
    valid_E = 1'b1; write_reg_E = 5'd20; reg_write_E = 1'b1;
    #1;
    check({tag, "_busy_t0"}, 32'(busy_E), 32'd1);
    for (int k = 1; k < MC; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_bubble"}, 32'(valid_M), 32'd0);
      // Forwarding noise while busy must not reach the product.
      fa = 2'b10;
      alu_result_M_fwd = $urandom;
      #1;
      check({tag, "_busy"}, 32'(busy_E), 32'd1);
    end
    @(posedge clk);
    #1;
    check({tag, "_bubble_last"}, 32'(valid_M), 32'd0);
    #1;
    check({tag, "_busy_done"}, 32'(busy_E), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"},  32'(valid_M), 32'd1);
    check({tag, "_result"}, alu_result_M, exp);
    check({tag, "_wr"},     32'(write_reg_M), 32'd20);
    check({tag, "_rw"},     32'(reg_write_M), 32'd1);
    drive_idle();
    #1;
    check({tag, "_busy_after"}, 32'(busy_E), 32'd0);
  endtask
`endif

  // ---------------- test ----------------
  vec_t vecs[$];
  m_t   exp_m;
  m_t   zero_m;

  initial begin
    zero_m = '{valid: 1'b0, res: '0, wd: '0, wr: '0, rw: 1'b0, mr: 1'b0, mw: 1'b0};

    //            op    rs            rt         imm       src fa fb mf   w      st fl vl wr  rw mr mw | ev res           wd       wr  rw mr mw
    vecs.push_back(mk(0,  5,            7,         0,        0, 0, 0, 0,   0,     0, 0, 1, 3,  1, 0, 0,  1, 12,           7,       3,  1, 0, 0));
    vecs.push_back(mk(0,  'h11,         'h22,      1,        1, 2, 0, 100, 0,     0, 0, 1, 4,  1, 0, 0,  1, 101,          'h22,    4,  1, 0, 0));
    vecs.push_back(mk(0,  4,            'h33,      8,        1, 0, 1, 0,   9,     0, 0, 1, 0,  0, 0, 1,  1, 12,           9,       0,  0, 0, 1));
    vecs.push_back(mk(0,  1,            2,         0,        0, 0, 0, 0,   0,     1, 1, 1, 5,  1, 1, 0,  0, 0,            0,       0,  0, 0, 0));
    vecs.push_back(mk(0,  0,            3,         0,        1, 1, 0, 0,   'h55,  0, 0, 1, 6,  1, 0, 0,  1, 'h55,         3,       6,  1, 0, 0));
    vecs.push_back(mk(9,  'h80000000,   0,         4,        1, 0, 0, 0,   0,     0, 0, 1, 7,  1, 0, 0,  1, 'hF8000000,   0,       7,  1, 0, 0));
    vecs.push_back(mk(5,  'hFFFFFFFF,   1,         0,        0, 0, 0, 0,   0,     0, 0, 1, 8,  1, 0, 0,  1, 1,            1,       8,  1, 0, 0));
    vecs.push_back(mk(6,  'hFFFFFFFF,   1,         0,        0, 0, 0, 0,   0,     0, 0, 1, 9,  1, 0, 0,  1, 0,            1,       9,  1, 0, 0));
    vecs.push_back(mk(1,  3,            5,         0,        0, 0, 0, 0,   0,     0, 0, 1, 10, 1, 0, 0,  1, 'hFFFFFFFE,   5,       10, 1, 0, 0));
    vecs.push_back(mk(10, 0,            0,         'h1234,   1, 0, 0, 0,   0,     0, 0, 1, 11, 1, 0, 0,  1, 'h12340000,   0,       11, 1, 0, 0));
    vecs.push_back(mk(0,  9,            9,         0,        0, 0, 0, 0,   0,     1, 0, 1, 12, 1, 1, 1,  1, 'h12340000,   0,       11, 1, 0, 0));
    vecs.push_back(mk(0,  1,            1,         0,        0, 0, 0, 0,   0,     0, 0, 0, 13, 1, 1, 1,  0, 2,            1,       13, 0, 0, 0));
    vecs.push_back(mk(13, 'hAAAA,       'h5555,    0,        0, 0, 0, 0,   0,     0, 0, 1, 14, 1, 0, 0,  1, 0,            'h5555,  14, 1, 0, 0));
    vecs.push_back(mk(0,  10,           5,         0,        0, 3, 3, 99,  88,    0, 0, 1, 15, 1, 0, 0,  1, 15,           5,       15, 1, 0, 0));
    vecs.push_back(mk(2,  'hF0F0,       'hFF00,    0,        0, 0, 0, 0,   0,     0, 0, 1, 16, 1, 0, 0,  1, 'hF000,       'hFF00,  16, 1, 0, 0));
    vecs.push_back(mk(3,  'hF0F0,       'hFF00,    0,        0, 0, 0, 0,   0,     0, 0, 1, 17, 1, 0, 0,  1, 'hFFF0,       'hFF00,  17, 1, 0, 0));
    vecs.push_back(mk(4,  'hF0F0,       'hFF00,    0,        0, 0, 0, 0,   0,     0, 0, 1, 18, 1, 0, 0,  1, 'h0FF0,       'hFF00,  18, 1, 0, 0));
    vecs.push_back(mk(7,  1,            0,         31,       1, 0, 0, 0,   0,     0, 0, 1, 19, 1, 0, 0,  1, 'h80000000,   0,       19, 1, 0, 0));
    vecs.push_back(mk(8,  'h80000000,   'h23,      0,        0, 0, 0, 0,   0,     0, 0, 1, 20, 1, 0, 0,  1, 'h10000000,   'h23,    20, 1, 0, 0));
    vecs.push_back(mk(0,  'h100,        1,         4,        1, 0, 2, 'h77, 0,    0, 0, 1, 21, 1, 1, 0,  1, 'h104,        'h77,    21, 1, 1, 0));
    vecs.push_back(mk(0,  1,            2,         0,        0, 0, 0, 0,   0,     0, 1, 1, 22, 1, 0, 1,  0, 0,            0,       0,  0, 0, 0));
`ifndef EX_MUL_EN
    vecs.push_back(mk(11, 3,            4,         0,        0, 0, 0, 0,   0,     0, 0, 1, 23, 1, 0, 0,  1, 0,            4,       23, 1, 0, 0));
`endif

    // ---- reset state ----
    do_reset();
    check_m("reset", zero_m);
    check("reset_busy_E", 32'(busy_E), 32'd0);
    check("reset_fsm_state", 32'(mul_state_dbg), 32'd0);

    // ---- directed table ----
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_busy_E", i), 32'(busy_E), 32'd0);
      @(posedge clk);
      #1;
      check_m($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---- randomized traffic vs. reference model ----
    do_reset();
    exp_m = zero_m;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, bf, b;
      alu_op_E = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
      if (alu_op_E == 4'd11) alu_op_E = 4'd0;
`endif
      rs_data_E = $urandom; rt_data_E = $urandom; imm_E = $urandom;
      if ($urandom_range(0, 3) == 0) rs_data_E = 32'h8000_0000 | 32'($urandom_range(0, 3));
      alu_src_E = 1'($urandom_range(0, 1));
      fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
      alu_result_M_fwd = $urandom; result_W = $urandom;
      stall_e = ($urandom_range(0, 7) == 0);
      flush_m = ($urandom_range(0, 7) == 0);
      valid_E = ($urandom_range(0, 5) != 0);
      write_reg_E = 5'($urandom_range(0, 31));
      reg_write_E = 1'($urandom_range(0, 1));
      mem_to_reg_E = 1'($urandom_range(0, 1));
      mem_write_E = 1'($urandom_range(0, 1));

      a  = ref_fwd(fa, rs_data_E, alu_result_M_fwd, result_W);
      bf = ref_fwd(fb, rt_data_E, alu_result_M_fwd, result_W);
      b  = alu_src_E ? imm_E : bf;
      if (flush_m) begin
        exp_m = zero_m;
      end else if (!stall_e) begin
        exp_m.valid = valid_E;
        exp_m.res   = ref_alu(alu_op_E, a, b);
        exp_m.wd    = bf;
        exp_m.wr    = write_reg_E;
        exp_m.rw    = reg_write_E & valid_E;
        exp_m.mr    = mem_to_reg_E & valid_E;
        exp_m.mw    = mem_write_E & valid_E;
      end
      #1;
      check($sformatf("rnd%0d_busy_E", n), 32'(busy_E), 32'd0);
      @(posedge clk);
      #1;
      check_m($sformatf("rnd%0d", n), exp_m);
    end

`ifdef EX_MUL_EN
    // ---- multi-cycle multiply ----
    do_reset();
    run_mul("mul_wrap", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_mul("mul_small", 32'd1234, 32'd5678, 32'd7006652);

    // ---- reset in the middle of a multiply ----
    drive_idle();
    alu_op_E = 4'd11; rs_data_E = 32'd3; imm_E = 32'd3; alu_src_E = 1'b1;
    valid_E = 1'b1; write_reg_E = 5'd20; reg_write_E = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_idle();
    #1;
    check("rst_mid_busy_E", 32'(busy_E), 32'd0);
    check("rst_mid_valid_M", 32'(valid_M), 32'd0);
    check("rst_mid_fsm_idle", 32'(mul_state_dbg), 32'd0);
    @(posedge clk);
    #1;
    run_mul("mul_after_rst", 32'd7, 32'd6, 32'd42);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
